// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the multi-cycle RV32I sequencer:
// FSM states, opcode encodings and the instruction classes the decoder produces.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_UPDATE    = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OC_ALU     = 3'd0,
        OC_LOAD    = 3'd1,
        OC_STORE   = 3'd2,
        OC_BRANCH  = 3'd3,
        OC_JUMP    = 3'd4,
        OC_FENCE   = 3'd5,
        OC_SYSTEM  = 3'd6,
        OC_ILLEGAL = 3'd7
    } opclass_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/rv_opclass.sv
// Purely combinational opcode classifier; the sequencer steers its FSM from
// the class rather than from raw opcode bits.
module rv_opclass
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   opclass
);

    always_comb begin
        opclass = OC_ILLEGAL;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: opclass = OC_ALU;
            OPC_JAL, OPC_JALR:                      opclass = OC_JUMP;
            OPC_BRANCH:                             opclass = OC_BRANCH;
            OPC_LOAD:                               opclass = OC_LOAD;
            OPC_STORE:                              opclass = OC_STORE;
            OPC_MISC_MEM:                           opclass = OC_FENCE;
            OPC_SYSTEM:                             opclass = OC_SYSTEM;
            default:                                opclass = OC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC / fetch sequencer: owns the architectural PC, walks each
// instruction through fetch, decode, execute, memory, writeback and PC update.
module pc_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] target_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic        pc_update,
    output logic        halted,
    output logic        fault
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] tgt_q, tgt_d;
    logic        take_q, take_d;
    logic        fault_q, fault_d;

    opclass_t    opclass;
    logic [31:0] next_pc;
    logic        misaligned;

    rv_opclass u_opclass (
        .opcode  (instr_q[6:0]),
        .opclass (opclass)
    );

    // The redirect decision is frozen in EXECUTE, so UPDATE depends only on flops.
    assign next_pc    = take_q ? tgt_q : pc_q + PC_STEP;
    assign misaligned = |next_pc[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        tgt_d   = tgt_q;
        take_d  = take_q;
        fault_d = fault_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opclass)
                    OC_SYSTEM:  state_d = ST_HALT;
                    OC_ILLEGAL: begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end
                    default:    state_d = ST_EXECUTE;
                endcase
            end
            ST_EXECUTE: begin
                take_d = (opclass == OC_JUMP) || ((opclass == OC_BRANCH) && branch_taken);
                if (take_d) tgt_d = target_addr;
                case (opclass)
                    OC_LOAD, OC_STORE:  state_d = ST_MEM;
                    OC_BRANCH, OC_FENCE: state_d = ST_UPDATE;
                    default:            state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) state_d = (opclass == OC_LOAD) ? ST_WRITEBACK : ST_UPDATE;
            end
            ST_WRITEBACK: state_d = ST_UPDATE;
            ST_UPDATE: begin
                if (misaligned) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            tgt_q   <= '0;
            take_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            tgt_q   <= tgt_d;
            take_q  <= take_d;
            fault_q <= fault_d;
        end
    end

    // Every output is a state decode or a flop; only imem_addr mirrors pc.
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign dmem_req  = (state_q == ST_MEM);
    assign dmem_we   = (state_q == ST_MEM) && (opclass == OC_STORE);
    assign rf_we     = (state_q == ST_WRITEBACK);
    assign pc_update = (state_q == ST_UPDATE) && !misaligned;
    assign halted    = (state_q == ST_HALT);
    assign fault     = fault_q;
    assign instr     = instr_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected rf_we / pc_update /
// halt events into a queue and a negedge monitor pops and checks them.
module tb_pc_sequencer;

    localparam int K_RF   = 0;
    localparam int K_PCU  = 1;
    localparam int K_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata, instr, pc, target_addr;
    logic        branch_taken, dmem_req, dmem_we, dmem_ready;
    logic        rf_we, pc_update, halted, fault;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .pc           (pc),
        .branch_taken (branch_taken),
        .target_addr  (target_addr),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .rf_we        (rf_we),
        .pc_update    (pc_update),
        .halted       (halted),
        .fault        (fault)
    );

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] val;
    } ev_t;

    ev_t         sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          t0       = 0;
    logic [31:0] exp_pc   = 32'h0;
    logic        halted_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expected event per observed DUT event.
    always @(negedge clk) begin
        ev_t e;
        int  rel;
        rel = cyc - t0 + 1;
        if (halted === 1'b1 && !halted_prev) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_halt: halted rose with nothing expected");
            end else begin
                e = sb.pop_front();
                chk("halt_kind", e.kind, K_HALT);
                chk("halt_cycle", rel, e.cyc);
                chk("halt_fault", {31'h0, fault}, e.val);
            end
        end
        halted_prev = (halted === 1'b1);
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rf_we: rf_we high with nothing expected");
            end else begin
                e = sb.pop_front();
                chk("rf_kind", e.kind, K_RF);
                chk("rf_cycle", rel, e.cyc);
                chk("rf_instr", instr, e.val);
            end
        end
        if (pc_update === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_pc_update: pc_update high with nothing expected");
            end else begin
                e = sb.pop_front();
                chk("pcu_kind", e.kind, K_PCU);
                chk("pcu_cycle", rel, e.cyc);
                @(posedge clk);
                #1;
                chk("pcu_new_pc", pc, e.val);
            end
        end
    end

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ready  = 1'b0;
        dmem_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'h0;
    endtask

    // Issue one instruction; ready waits are counted from the first request cycle.
    task automatic run(input logic [31:0] ins, input int iw, input int dw,
                       input logic tk, input logic [31:0] tg);
        logic [6:0]  opc;
        logic        alu, jmp, ld, st, br, fn, sy, wb, mem;
        logic [31:0] npc, pc0, prev_instr;
        int          u, icnt, dcnt, wcnt, addr_bad, instr_bad;
        ev_t         e;
        bit          done;
        opc = ins[6:0];
        alu = (opc == 7'b0110111) || (opc == 7'b0010111) || (opc == 7'b0010011) || (opc == 7'b0110011);
        jmp = (opc == 7'b1101111) || (opc == 7'b1100111);
        ld  = (opc == 7'b0000011);
        st  = (opc == 7'b0100011);
        br  = (opc == 7'b1100011);
        fn  = (opc == 7'b0001111);
        sy  = (opc == 7'b1110011);
        wb  = alu || jmp || ld;
        mem = ld || st;
        pc0 = exp_pc;
        npc = (jmp || (br && tk)) ? tg : exp_pc + 32'd4;
        if (sy || !(alu || jmp || ld || st || br || fn)) begin
            e.kind = K_HALT; e.cyc = 3 + iw; e.val = sy ? 32'd0 : 32'd1;
            sb.push_back(e);
        end else begin
            u = 3 + iw + (mem ? 1 + dw : 0) + (wb ? 1 : 0) + 1;
            if (wb) begin
                e.kind = K_RF; e.cyc = u - 1; e.val = ins;
                sb.push_back(e);
            end
            if (npc[1:0] != 2'b00) begin
                e.kind = K_HALT; e.cyc = u + 1; e.val = 32'd1;
                sb.push_back(e);
            end else begin
                e.kind = K_PCU; e.cyc = u; e.val = npc;
                sb.push_back(e);
                exp_pc = npc;
            end
        end

        t0 = cyc;
        imem_rdata   = ins;
        branch_taken = tk;
        target_addr  = tg;
        prev_instr   = instr;
        icnt = 0; dcnt = 0; wcnt = 0; addr_bad = 0; instr_bad = 0; done = 0;
        for (int k = 0; k < 60; k++) begin
            if (pc_update || halted) begin
                done = 1;
                break;
            end
            if (imem_req) begin
                if (imem_addr !== pc0) addr_bad++;
                if (instr !== prev_instr) instr_bad++;
                imem_ready = (icnt == iw);
                icnt++;
            end else begin
                imem_ready = 1'b0;
            end
            if (dmem_req) begin
                dmem_ready = (dcnt == dw);
                dcnt++;
                if (dmem_we) wcnt++;
            end else begin
                dmem_ready = 1'b0;
            end
            @(negedge clk);
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL timeout: instr %h never completed", ins);
        end
        @(negedge clk);
        chk("fetch_cycles", icnt, iw + 1);
        chk("fetch_addr_stable", addr_bad, 0);
        chk("instr_held_during_wait", instr_bad, 0);
        chk("instr_latched", instr, ins);
        chk("dmem_req_cycles", dcnt, mem ? dw + 1 : 0);
        chk("dmem_we_cycles", wcnt, st ? dw + 1 : 0);
        chk("pc_after", pc, exp_pc);
    endtask

    initial begin
        int seen;
        imem_rdata   = 32'h0;
        branch_taken = 1'b0;
        target_addr  = 32'h0;
        do_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_quiet", {27'h0, dmem_req, dmem_we, rf_we, pc_update, halted}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);

        run(32'h0050_0093, 0, 0, 1'b0, 32'h0);          // ADDI, zero wait
        run(32'h0010_0113, 3, 0, 1'b0, 32'h0);          // ADDI, slow fetch
        run(32'h0000_006F, 0, 0, 1'b0, 32'h0000_0010);  // JAL -> 0x10
        run(32'h0000_0063, 0, 0, 1'b1, 32'h0000_0040);  // BEQ taken
        run(32'h0000_006F, 0, 0, 1'b0, 32'h0000_0010);
        run(32'h0000_0063, 0, 0, 1'b0, 32'h0000_0040);  // BEQ not taken -> 0x14
        run(32'h0011_2023, 0, 1, 1'b0, 32'h0);          // SW
        run(32'h0001_2183, 0, 2, 1'b0, 32'h0);          // LW, 8 cycles
        run(32'h0000_000F, 0, 0, 1'b0, 32'h0);          // FENCE
        run(32'h1234_50B7, 0, 0, 1'b0, 32'h0);          // LUI
        run(32'h0000_0097, 1, 0, 1'b0, 32'h0);          // AUIPC
        run(32'h0020_81B3, 0, 0, 1'b0, 32'h0);          // OP
        run(32'h0000_006F, 0, 0, 1'b0, 32'hFFFF_FFFC);  // JAL to top of memory
        run(32'h0050_0093, 0, 0, 1'b0, 32'h0);          // ADDI wraps to 0

        // Reset in the middle of a stalled load.
        imem_rdata = 32'h0001_2183;
        seen = 0;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            imem_ready = imem_req;
            if (dmem_req) seen++;
            @(negedge clk);
        end
        imem_ready = 1'b0;
        chk("midmem_reached", seen, 2);
        exp_pc = 32'h1234_0000;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midmem_dmem_req_drop", {31'h0, dmem_req}, 32'h0);
        chk("midmem_pc_reset", pc, 32'h0);
        chk("midmem_instr_reset", instr, 32'h0000_0013);
        rst_n  = 1'b1;
        exp_pc = 32'h0;

        run(32'h0000_8067, 0, 0, 1'b0, 32'h0000_0102);  // JALR misaligned
        chk("jalr_fault", {30'h0, halted, fault}, 32'h3);
        do_reset();
        run(32'hFFFF_FFFF, 0, 0, 1'b0, 32'h0);          // illegal opcode
        do_reset();
        run(32'h0000_0073, 2, 0, 1'b0, 32'h0);          // ECALL

        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("halt_sticky", {27'h0, halted, imem_req, dmem_req, rf_we, pc_update}, 32'h10);
        chk("halt_no_fault", {31'h0, fault}, 32'h0);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        do_reset();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
